// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC register, fetch FSM (FETCH/MISS/FULL) and an instruction queue.
// Optional static JAL target prediction is enabled by defining IFETCH_JAL_PREDICT_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          IFQ_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic [31:0] icache_addr,
    input  logic [31:0] icache_data,
    input  logic        icache_len,
    input  logic        icache_hit,
    input  logic        flush_in,
    input  logic [31:0] flush_pc,
    output logic        ifq_valid,
    output logic [31:0] ifq_inst,
    output logic [31:0] ifq_pc,
    output logic        ifq_len,
    output logic        ifq_pred_taken,
    output logic [31:0] ifq_pred_pc,
    input  logic        dec_ready
);

    localparam int PTR_W = $clog2(IFQ_DEPTH);
    localparam int CNT_W = $clog2(IFQ_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IFQ_DEPTH);

    typedef enum logic [1:0] {FETCH, MISS, FULL} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred_pc;
        logic        len;
        logic        pred_taken;
    } entry_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             mem_q [IFQ_DEPTH];

    logic [31:0] fetch_pc;
    logic [31:0] seq_pc;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        full;
    logic        enq;
    logic        deq;
    entry_t      head;

    assign fetch_pc    = pc_q & ~32'h1;
    assign icache_addr = fetch_pc;
    assign seq_pc      = fetch_pc + (icache_len ? 32'd4 : 32'd2);

`ifdef IFETCH_JAL_PREDICT_EN
    logic [31:0] jal_imm;
    assign jal_imm    = {{11{icache_data[31]}}, icache_data[31], icache_data[19:12],
                         icache_data[20], icache_data[30:21], 1'b0};
    assign pred_taken = icache_len && (icache_data[6:0] == 7'b1101111);
    assign pred_pc    = pred_taken ? fetch_pc + jal_imm : seq_pc;
`else
    assign pred_taken = 1'b0;
    assign pred_pc    = seq_pc;
`endif

    // Fullness uses the count registered at the start of the cycle, so a same-cycle
    // dequeue only frees a slot for the following cycle.
    assign full      = (count_q == DEPTH_C);
    assign ifq_valid = (count_q != '0);
    assign deq       = ifq_valid && dec_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        enq      = 1'b0;

        if (flush_in) begin
            state_d  = FETCH;
            pc_d     = flush_pc & ~32'h1;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (state_q)
                FETCH, MISS: begin
                    if (full) begin
                        state_d = FULL;
                    end else if (icache_hit) begin
                        enq     = 1'b1;
                        pc_d    = pred_pc;
                        state_d = FETCH;
                    end else begin
                        state_d = MISS;
                    end
                end
                FULL:    state_d = (full && !deq) ? FULL : FETCH;
                default: state_d = FETCH;
            endcase

            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (rdy_in) begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: queue storage has no reset; entries are only visible through the count,
    // and the head outputs are masked to zero whenever the queue is empty.
    always_ff @(posedge clk_in) begin
        if (rdy_in && enq) begin
            mem_q[wr_ptr_q] <= '{inst: icache_data, pc: fetch_pc, pred_pc: pred_pc,
                                 len: icache_len, pred_taken: pred_taken};
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign ifq_inst       = ifq_valid ? head.inst       : 32'h0;
    assign ifq_pc         = ifq_valid ? head.pc         : 32'h0;
    assign ifq_pred_pc    = ifq_valid ? head.pred_pc    : 32'h0;
    assign ifq_len        = ifq_valid ? head.len        : 1'b0;
    assign ifq_pred_taken = ifq_valid ? head.pred_taken : 1'b0;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch (default parameters); expectations are
// hand-computed fetch addresses, queue heads and predictions.
module tb_inst_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] icache_addr;
    logic [31:0] icache_data;
    logic        icache_len;
    logic        icache_hit;
    logic        flush_in;
    logic [31:0] flush_pc;
    logic        ifq_valid;
    logic [31:0] ifq_inst;
    logic [31:0] ifq_pc;
    logic        ifq_len;
    logic        ifq_pred_taken;
    logic [31:0] ifq_pred_pc;
    logic        dec_ready;

    int tests_run = 0;
    int tests_failed = 0;

    inst_fetch dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .icache_addr    (icache_addr),
        .icache_data    (icache_data),
        .icache_len     (icache_len),
        .icache_hit     (icache_hit),
        .flush_in       (flush_in),
        .flush_pc       (flush_pc),
        .ifq_valid      (ifq_valid),
        .ifq_inst       (ifq_inst),
        .ifq_pc         (ifq_pc),
        .ifq_len        (ifq_len),
        .ifq_pred_taken (ifq_pred_taken),
        .ifq_pred_pc    (ifq_pred_pc),
        .dec_ready      (dec_ready)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_flush(input logic [31:0] target);
        flush_in   = 1'b1;
        flush_pc   = target;
        icache_hit = 1'b0;
        dec_ready  = 1'b0;
        tick();
        flush_in   = 1'b0;
    endtask

    logic [31:0] fpc;

    initial begin
        rst_in      = 1'b0;
        rdy_in      = 1'b1;
        icache_data = 32'h0;
        icache_len  = 1'b0;
        icache_hit  = 1'b0;
        flush_in    = 1'b0;
        flush_pc    = 32'h0;
        dec_ready   = 1'b0;

        // Reset state
        #3;
        check("rst_valid", {31'b0, ifq_valid}, 32'h0);
        check("rst_addr", icache_addr, 32'h0);
        check("rst_inst", ifq_inst, 32'h0);
        check("rst_pc", ifq_pc, 32'h0);
        check("rst_pred_pc", ifq_pred_pc, 32'h0);
        check("rst_len_taken", {30'b0, ifq_len, ifq_pred_taken}, 32'h0);
        tick();
        tick();

        // Mixed-length sequential fetch with immediate dequeue
        rst_in      = 1'b1;
        dec_ready   = 1'b1;
        icache_hit  = 1'b1;
        icache_data = 32'h0000_0013;
        icache_len  = 1'b1;
        check("seq_addr0", icache_addr, 32'h0);
        tick();
        check("seq_addr1", icache_addr, 32'h4);
        check("seq_valid1", {31'b0, ifq_valid}, 32'h1);
        check("seq_pc0", ifq_pc, 32'h0);
        check("seq_inst0", ifq_inst, 32'h0000_0013);
        check("seq_pred0", ifq_pred_pc, 32'h4);
        icache_data = 32'h0000_0001;
        icache_len  = 1'b0;
        tick();
        check("seq_addr2", icache_addr, 32'h6);
        check("seq_pc1", ifq_pc, 32'h4);
        check("seq_len1", {31'b0, ifq_len}, 32'h0);
        check("seq_pred1", ifq_pred_pc, 32'h6);
        icache_data = 32'h0000_0013;
        icache_len  = 1'b1;
        tick();
        check("seq_addr3", icache_addr, 32'hA);
        check("seq_pc2", ifq_pc, 32'h6);
        check("seq_pred2", ifq_pred_pc, 32'hA);

        // Three-cycle miss at 0x8
        do_flush(32'h8);
        check("miss_flush_addr", icache_addr, 32'h8);
        check("miss_flush_valid", {31'b0, ifq_valid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("miss_hold_addr%0d", i), icache_addr, 32'h8);
            check($sformatf("miss_hold_valid%0d", i), {31'b0, ifq_valid}, 32'h0);
        end
        icache_hit  = 1'b1;
        icache_data = 32'h1234_5673;
        icache_len  = 1'b1;
        tick();
        check("miss_hit_addr", icache_addr, 32'hC);
        check("miss_hit_pc", ifq_pc, 32'h8);
        check("miss_hit_inst", ifq_inst, 32'h1234_5673);
        icache_hit = 1'b0;
        dec_ready  = 1'b1;
        tick();
        check("miss_single_enq", {31'b0, ifq_valid}, 32'h0);

        // Flush beats a simultaneous hit and dequeue; rdy_in=0 then freezes everything
        dec_ready  = 1'b0;
        icache_hit = 1'b1;
        tick();
        check("fl_pre_valid", {31'b0, ifq_valid}, 32'h1);
        check("fl_pre_addr", icache_addr, 32'h10);
        flush_in  = 1'b1;
        flush_pc  = 32'h101;
        dec_ready = 1'b1;
        tick();
        check("fl_valid", {31'b0, ifq_valid}, 32'h0);
        check("fl_addr", icache_addr, 32'h100);
        rdy_in   = 1'b0;
        flush_pc = 32'h200;
        tick();
        check("rdy_hold_addr", icache_addr, 32'h100);
        check("rdy_hold_valid", {31'b0, ifq_valid}, 32'h0);
        rdy_in   = 1'b1;
        flush_in = 1'b0;

        // JAL at 0x20 with imm -8
        do_flush(32'h20);
        icache_hit  = 1'b1;
        icache_data = 32'hFF9F_F06F;
        icache_len  = 1'b1;
        tick();
        check("jal_pc", ifq_pc, 32'h20);
`ifdef IFETCH_JAL_PREDICT_EN
        check("jal_taken", {31'b0, ifq_pred_taken}, 32'h1);
        check("jal_pred_pc", ifq_pred_pc, 32'h18);
        check("jal_next_addr", icache_addr, 32'h18);
`else
        check("jal_taken", {31'b0, ifq_pred_taken}, 32'h0);
        check("jal_pred_pc", ifq_pred_pc, 32'h24);
        check("jal_next_addr", icache_addr, 32'h24);
`endif

        // Fill the queue, free one slot, then drain and verify every entry once
        do_flush(32'h40);
        icache_hit = 1'b1;
        icache_len = 1'b1;
        fpc = 32'h40;
        for (int i = 0; i < 12; i++) begin
            icache_data = {16'hBEEF, fpc[15:0]};
            tick();
            if (i < 8) fpc = fpc + 32'd4;
            check($sformatf("fill_addr%0d", i), icache_addr, fpc);
        end
        check("fill_head", ifq_pc, 32'h40);
        dec_ready = 1'b1;
        tick();
        check("full_deq_head", ifq_pc, 32'h44);
        check("full_deq_addr", icache_addr, 32'h60);
        dec_ready   = 1'b0;
        icache_data = 32'hBEEF_0060;
        tick();
        check("resume_addr", icache_addr, 32'h64);
        tick();
        check("refull_addr", icache_addr, 32'h64);
        icache_hit = 1'b0;
        dec_ready  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            fpc = 32'h44 + 32'(4 * k);
            check($sformatf("drain_pc%0d", k), ifq_pc, fpc);
            check($sformatf("drain_inst%0d", k), ifq_inst, {16'hBEEF, fpc[15:0]});
            tick();
        end
        check("drain_empty", {31'b0, ifq_valid}, 32'h0);

        // Asynchronous reset with five entries queued
        do_flush(32'h80);
        icache_hit  = 1'b1;
        icache_data = 32'h0000_0013;
        icache_len  = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        icache_hit = 1'b0;
        check("ar_pre_valid", {31'b0, ifq_valid}, 32'h1);
        check("ar_pre_pc", ifq_pc, 32'h80);
        #2;
        rst_in = 1'b0;
        #1;
        check("ar_valid", {31'b0, ifq_valid}, 32'h0);
        check("ar_addr", icache_addr, 32'h0);
        check("ar_pc", ifq_pc, 32'h0);
        rst_in     = 1'b1;
        icache_hit = 1'b1;
        dec_ready  = 1'b0;
        tick();
        check("ar_first_pc", ifq_pc, 32'h0);
        check("ar_first_valid", {31'b0, ifq_valid}, 32'h1);
        check("ar_next_addr", icache_addr, 32'h4);
        tick();
        check("ar_head_stable", ifq_pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
